// File: rtl/ysyx_23060171_mem_responder.sv
// Handshaked, latency-configurable memory slave with independent read
// (AR/R) and write (AW/W/B) channels over a byte-strobed word array.
//
// Read FSM
//   state  | meaning
//   R_IDLE | accepting a read address
//   R_WAIT | counting down the read latency
//   R_RESP | holding rdata/rresp until rready
//
// Write FSM
//   state  | meaning
//   W_IDLE | collecting AW and W in any order
//   W_WAIT | counting down the write latency
//   W_RESP | holding bresp until bready
module ysyx_23060171_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned RD_LAT      = 2,
  parameter int unsigned WR_LAT      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN_END = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  RD_CNT   = 4'(RD_LAT - 1);
  localparam logic [3:0]  WR_CNT   = 4'(WR_LAT - 1);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  logic [31:0] mem [DEPTH_WORDS];

  // 33-bit compare so a window ending at 2^32 does not wrap
  function automatic logic in_range(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < SPAN_END);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  // ---------------- read channel ----------------
  r_state_t    r_state, r_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_sel_addr;
  logic        r_enter;

  // with zero latency the sample happens on the handshake edge itself
  assign r_sel_addr = (r_state == R_IDLE) ? araddr : r_addr;
  assign r_enter    = (r_state != R_RESP) && (r_next == R_RESP);

  // read state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= R_IDLE;
    else      r_state <= r_next;
  end

  // read next-state logic
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (arvalid) r_next = (RD_LAT == 0) ? R_RESP : R_WAIT;
      R_WAIT:  if (r_cnt == 4'd0) r_next = R_RESP;
      R_RESP:  if (rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // read handshake outputs
  always_comb begin
    arready = (r_state == R_IDLE);
    rvalid  = (r_state == R_RESP);
  end

  // read address latch, latency counter and response capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= 4'd0;
      r_addr <= 32'd0;
      rdata  <= 32'd0;
      rresp  <= 2'b00;
    end else begin
      if (arvalid && arready) begin
        r_addr <= araddr;
        r_cnt  <= RD_CNT;
      end else if (r_state == R_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_enter) begin
        if (in_range(r_sel_addr)) begin
          rdata <= mem[word_idx(r_sel_addr)];
          rresp <= 2'b00;
        end else begin
          rdata <= 32'd0;
          rresp <= 2'b10;
        end
      end
    end
  end

  // ---------------- write channel ----------------
  w_state_t    w_state, w_next;
  logic [3:0]  w_cnt;
  logic        aw_got, w_got;
  logic [31:0] aw_addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_hs, w_hs, both_now, w_commit, w_ok;
  logic [31:0] eff_addr, eff_data;
  logic [3:0]  eff_strb;

  assign aw_hs    = awvalid & awready;
  assign w_hs     = wvalid & wready;
  assign both_now = (aw_got | aw_hs) & (w_got | w_hs);
  // the latched copy wins once captured; otherwise the live bus is being captured now
  assign eff_addr = aw_got ? aw_addr_q : awaddr;
  assign eff_data = w_got ? wdata_q : wdata;
  assign eff_strb = w_got ? wstrb_q : wstrb;
  assign w_ok     = in_range(eff_addr);
  assign w_commit = (w_state != W_RESP) && (w_next == W_RESP);

  // write state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) w_state <= W_IDLE;
    else      w_state <= w_next;
  end

  // write next-state logic
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (both_now) w_next = (WR_LAT == 0) ? W_RESP : W_WAIT;
      W_WAIT:  if (w_cnt == 4'd0) w_next = W_RESP;
      W_RESP:  if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // write handshake outputs
  always_comb begin
    awready = (w_state == W_IDLE) && !aw_got;
    wready  = (w_state == W_IDLE) && !w_got;
    bvalid  = (w_state == W_RESP);
  end

  // AW/W capture flags, latency counter and response code
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      aw_addr_q <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      w_cnt     <= 4'd0;
      bresp     <= 2'b00;
    end else begin
      if (w_state == W_RESP && bready) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_got    <= 1'b1;
          aw_addr_q <= awaddr;
        end
        if (w_hs) begin
          w_got   <= 1'b1;
          wdata_q <= wdata;
          wstrb_q <= wstrb;
        end
      end
      if (w_state == W_IDLE && both_now) w_cnt <= WR_CNT;
      else if (w_state == W_WAIT && w_cnt != 4'd0) w_cnt <= w_cnt - 4'd1;
      if (w_commit) bresp <= w_ok ? 2'b00 : 2'b10;
    end
  end

  // backing store; a read sampling on the commit edge still sees the old word
  always_ff @(posedge clk) begin
    if (rst && w_commit && w_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (eff_strb[i]) mem[word_idx(eff_addr)][8*i +: 8] <= eff_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060171_mem_responder.sv
// Directed bench for the memory responder with a transaction-level model.
module tb_ysyx_23060171_mem_responder;

  localparam int unsigned RD_LAT = 2;
  localparam int unsigned WR_LAT = 1;
  localparam int unsigned DEPTH  = 4096;
  localparam logic [31:0] BASE   = 32'h8000_0000;

  logic        clk = 1'b0, rst = 1'b0;
  logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic [31:0] araddr = 32'd0, awaddr = 32'd0, wdata = 32'd0;
  logic [3:0]  wstrb = 4'd0;
  logic        arready, rvalid, awready, wready, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_23060171_mem_responder #(
    .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: memory as a sparse word map ----------------
  logic [31:0] mm [int unsigned];
  bit          m_rbusy, m_rknown;
  int          m_rtimer;
  logic [31:0] m_raddr, m_rdata;
  logic [1:0]  m_rresp;
  bit          m_haw, m_hw, commit;
  int          m_wtimer;
  logic [31:0] m_awaddr, m_wdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp;

  function automatic bit in_rng(input logic [31:0] a);
    return ({32'd0, a} >= {32'd0, BASE}) && ({32'd0, a} < {32'd0, BASE} + 64'(4 * DEPTH));
  endfunction

  task automatic sample_read();
    int unsigned k;
    if (in_rng(m_raddr)) begin
      k = (m_raddr - BASE) >> 2;
      m_rresp  = 2'b00;
      m_rknown = mm.exists(k);
      m_rdata  = m_rknown ? mm[k] : 32'd0;
    end else begin
      m_rresp  = 2'b10;
      m_rknown = 1'b1;
      m_rdata  = 32'd0;
    end
  endtask

  task automatic commit_write();
    int unsigned k;
    logic [31:0] w;
    if (in_rng(m_awaddr)) begin
      k = (m_awaddr - BASE) >> 2;
      if (mm.exists(k) || m_wstrb == 4'hF) begin
        w = mm.exists(k) ? mm[k] : 32'd0;
        for (int i = 0; i < 4; i++) if (m_wstrb[i]) w[8*i +: 8] = m_wdata[8*i +: 8];
        mm[k] = w;
      end
      m_bresp = 2'b00;
    end else begin
      m_bresp = 2'b10;
    end
  endtask

  // model advance: reads sample memory before this edge's write lands
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_rbusy = 0; m_rtimer = 0; m_haw = 0; m_hw = 0; m_wtimer = 0;
    end else begin
      if (!m_rbusy) begin
        if (arvalid) begin
          m_rbusy = 1; m_raddr = araddr; m_rtimer = RD_LAT;
          if (RD_LAT == 0) sample_read();
        end
      end else if (m_rtimer > 0) begin
        m_rtimer--;
        if (m_rtimer == 0) sample_read();
      end else if (rready) begin
        m_rbusy = 0;
      end
      commit = 0;
      if (m_haw && m_hw) begin
        if (m_wtimer > 0) begin
          m_wtimer--;
          if (m_wtimer == 0) commit = 1;
        end else if (bready) begin
          m_haw = 0; m_hw = 0;
        end
      end else begin
        if (!m_haw && awvalid) begin m_haw = 1; m_awaddr = awaddr; end
        if (!m_hw && wvalid) begin m_hw = 1; m_wdata = wdata; m_wstrb = wstrb; end
        if (m_haw && m_hw) begin m_wtimer = WR_LAT; commit = (WR_LAT == 0); end
      end
      if (commit) commit_write();
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    chk("arready", 32'(arready), 32'(!m_rbusy));
    chk("rvalid", 32'(rvalid), 32'(m_rbusy && m_rtimer == 0));
    chk("awready", 32'(awready), 32'(!m_haw));
    chk("wready", 32'(wready), 32'(!m_hw));
    chk("bvalid", 32'(bvalid), 32'(m_haw && m_hw && m_wtimer == 0));
    if (m_rbusy && m_rtimer == 0) begin
      chk("rresp", 32'(rresp), 32'(m_rresp));
      if (m_rknown) chk("rdata", rdata, m_rdata);
    end
    if (m_haw && m_hw && m_wtimer == 0) chk("bresp", 32'(bresp), 32'(m_bresp));
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_valid(input bit is_read, output int lat);
    lat = 1;
    forever begin
      @(negedge clk);
      if (is_read ? rvalid : bvalid) break;
      if (lat >= 30) begin
        checks++; errors++;
        $display("FAIL timeout actual=no_valid required=valid read=%0d", is_read);
        break;
      end
      lat++;
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int lat, output logic [1:0] resp);
    awvalid = 1; awaddr = a; wvalid = 1; wdata = d; wstrb = s;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    wait_valid(1'b0, lat);
    resp = bresp;
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output int lat);
    arvalid = 1; araddr = a;
    @(posedge clk); #1;
    arvalid = 0;
    wait_valid(1'b1, lat);
    d = rdata; resp = rresp;
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat;
    logic [31:0] d;
    logic [1:0]  r;

    // reset held for 3 cycles
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_awready", 32'(awready), 32'd1);
    chk("rst_wready", 32'(wready), 32'd1);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(posedge clk); #1;

    // full-word write then read
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, lat, r);
    chk("wr_lat", 32'(lat), 32'd2);
    chk("wr_bresp", 32'(r), 32'd0);
    do_read(32'h8000_0010, d, r, lat);
    chk("rd_lat", 32'(lat), 32'd3);
    chk("rd_data", d, 32'hDEAD_BEEF);
    chk("rd_resp", 32'(r), 32'd0);

    // byte strobes on middle lanes
    do_write(32'h8000_0010, 32'h00AA_5500, 4'b0110, lat, r);
    do_read(32'h8000_0012, d, r, lat);
    chk("strb_data", d, 32'hDEAA_55EF);

    // wstrb=0 leaves the word alone but still answers OKAY
    do_write(32'h8000_0010, 32'h1111_1111, 4'b0000, lat, r);
    chk("strb0_bresp", 32'(r), 32'd0);
    do_read(32'h8000_0010, d, r, lat);
    chk("strb0_data", d, 32'hDEAA_55EF);

    // AW at cycle 0, W at cycle 3
    awvalid = 1; awaddr = 32'h8000_0020;
    @(posedge clk); #1;
    awvalid = 0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin wvalid = 1; wdata = 32'h1122_3344; wstrb = 4'hF; end
      @(negedge clk);
      chk("split_awready", 32'(awready), 32'd0);
      @(posedge clk); #1;
    end
    wvalid = 0;
    wait_valid(1'b0, lat);
    chk("split_blat", 32'(lat), 32'd2);
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    do_read(32'h8000_0020, d, r, lat);
    chk("split_data", d, 32'h1122_3344);

    // read backpressure for 5 cycles
    arvalid = 1; araddr = 32'h8000_0010;
    @(posedge clk); #1;
    arvalid = 0;
    wait_valid(1'b1, lat);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      chk("bp_rdata", rdata, 32'hDEAA_55EF);
      chk("bp_rresp", 32'(rresp), 32'd0);
      chk("bp_arready", 32'(arready), 32'd0);
      chk("bp_rvalid", 32'(rvalid), 32'd1);
    end
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    @(negedge clk);
    chk("bp_rvalid_drop", 32'(rvalid), 32'd0);
    chk("bp_arready_back", 32'(arready), 32'd1);
    @(posedge clk); #1;

    // out-of-range read below the window
    do_read(32'h7FFF_FFFC, d, r, lat);
    chk("oor_rresp", 32'(r), 32'd2);
    chk("oor_rdata", d, 32'd0);

    // last in-range word and first out-of-range word
    do_write(32'h8000_3FFC, 32'hCAFE_F00D, 4'hF, lat, r);
    chk("last_bresp", 32'(r), 32'd0);
    do_read(32'h8000_3FFC, d, r, lat);
    chk("last_data", d, 32'hCAFE_F00D);
    do_write(32'h8000_0000, 32'h1234_5678, 4'hF, lat, r);
    do_write(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, lat, r);
    chk("oor_bresp", 32'(r), 32'd2);
    do_read(32'h8000_0000, d, r, lat);
    chk("word0_kept", d, 32'h1234_5678);

    // reset pulse while the read is waiting out its latency
    arvalid = 1; araddr = 32'h8000_0010;
    @(posedge clk); #1;
    arvalid = 0;
    #1 rst = 0;
    #1 rst = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rstmid_rvalid", 32'(rvalid), 32'd0);
      chk("rstmid_arready", 32'(arready), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
